// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arms on host request, waits for a trigger, then paces
// decimated sample writes into the capture FIFO with sticky done/overflow/timeout status.
module adc_capture_ctrl #(
  parameter int PRECISION     = 10,
  parameter int COUNT_WIDTH   = 16,
  parameter int DECIM_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PRECISION-1:0]     adc_code_in,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     sw_trig,
  input  logic [1:0]               trig_mode,
  input  logic [PRECISION-1:0]     trig_level,
  input  logic [COUNT_WIDTH-1:0]   num_samples,
  input  logic [DECIM_WIDTH-1:0]   decim,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [PRECISION-1:0]     fifo_din,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf_err,
  output logic                     tmo_err,
  output logic [COUNT_WIDTH-1:0]   sample_cnt,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] MODE_IMMEDIATE = 2'b00;
  localparam logic [1:0] MODE_SOFTWARE  = 2'b01;
  localparam logic [1:0] MODE_RISING    = 2'b10;

  state_t                   state_reg, state_next;
  logic [1:0]               mode_reg, mode_next;
  logic [PRECISION-1:0]     level_reg, level_next;
  logic [COUNT_WIDTH-1:0]   num_reg, num_next;
  logic [DECIM_WIDTH-1:0]   decim_reg, decim_next;
  logic [TIMEOUT_WIDTH-1:0] timeout_reg, timeout_next;
  logic [PRECISION-1:0]     prev_code_reg, prev_code_next;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [DECIM_WIDTH-1:0]   dcnt_reg, dcnt_next;
  logic [COUNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                     ovf_reg, ovf_next;
  logic                     tmo_err_reg, tmo_err_next;
  logic                     wr_en_reg, wr_en_next;
  logic [PRECISION-1:0]     din_reg, din_next;

  logic                     trig_hit;
  logic                     write_req;
  logic [COUNT_WIDTH-1:0]   cnt_inc;
  logic [TIMEOUT_WIDTH-1:0] tmo_inc;

  assign cnt_inc = cnt_reg + COUNT_WIDTH'(1);
  assign tmo_inc = tmo_cnt_reg + TIMEOUT_WIDTH'(1);

  // Level triggers compare the live sample against the one seen a cycle earlier.
  always_comb begin
    case (mode_reg)
      MODE_IMMEDIATE: trig_hit = 1'b1;
      MODE_SOFTWARE:  trig_hit = sw_trig;
      MODE_RISING:    trig_hit = (prev_code_reg < level_reg) && (adc_code_in >= level_reg);
      default:        trig_hit = (prev_code_reg >= level_reg) && (adc_code_in < level_reg);
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    level_next     = level_reg;
    num_next       = num_reg;
    decim_next     = decim_reg;
    timeout_next   = timeout_reg;
    prev_code_next = prev_code_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    dcnt_next      = dcnt_reg;
    cnt_next       = cnt_reg;
    ovf_next       = ovf_reg;
    tmo_err_next   = tmo_err_reg;
    wr_en_next     = 1'b0;
    din_next       = din_reg;
    write_req      = 1'b0;

    if (abort) begin
      // Abort preempts everything, including a coincident arm; status is held.
      if (state_reg != ST_IDLE) begin
        state_next = ST_IDLE;
      end
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            mode_next    = trig_mode;
            level_next   = trig_level;
            num_next     = num_samples;
            decim_next   = decim;
            timeout_next = timeout;
            cnt_next     = '0;
            ovf_next     = 1'b0;
            tmo_err_next = 1'b0;
            state_next   = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (num_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            prev_code_next = adc_code_in;
            tmo_cnt_next   = '0;
            state_next     = ST_WAIT_TRIG;
          end
        end

        ST_WAIT_TRIG: begin
          prev_code_next = adc_code_in;
          if (trig_hit) begin
            write_req  = 1'b1;
            dcnt_next  = '0;
            state_next = ST_CAPTURE;
          end else begin
            if (tmo_cnt_reg != '1) begin
              tmo_cnt_next = tmo_inc;
            end
            if ((timeout_reg != '0) && (tmo_inc == timeout_reg)) begin
              tmo_err_next = 1'b1;
              state_next   = ST_DONE;
            end
          end
        end

        ST_CAPTURE: begin
          if (dcnt_reg == decim_reg) begin
            write_req = 1'b1;
            dcnt_next = '0;
          end else begin
            dcnt_next = dcnt_reg + DECIM_WIDTH'(1);
          end
        end

        default: state_next = ST_IDLE;
      endcase

      // Shared by the trigger sample and every paced capture sample.
      if (write_req) begin
        if (fifo_full) begin
          ovf_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          wr_en_next = 1'b1;
          din_next   = adc_code_in;
          cnt_next   = cnt_inc;
          if (cnt_inc == num_reg) begin
            state_next = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= '0;
      level_reg     <= '0;
      num_reg       <= '0;
      decim_reg     <= '0;
      timeout_reg   <= '0;
      prev_code_reg <= '0;
      tmo_cnt_reg   <= '0;
      dcnt_reg      <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      tmo_err_reg   <= 1'b0;
      wr_en_reg     <= 1'b0;
      din_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      level_reg     <= level_next;
      num_reg       <= num_next;
      decim_reg     <= decim_next;
      timeout_reg   <= timeout_next;
      prev_code_reg <= prev_code_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      dcnt_reg      <= dcnt_next;
      cnt_reg       <= cnt_next;
      ovf_reg       <= ovf_next;
      tmo_err_reg   <= tmo_err_next;
      wr_en_reg     <= wr_en_next;
      din_reg       <= din_next;
    end
  end

  assign fifo_wr_en = wr_en_reg;
  assign fifo_din   = din_reg;
  assign sample_cnt = cnt_reg;
  assign ovf_err    = ovf_reg;
  assign tmo_err    = tmo_err_reg;
  assign state      = state_reg;
  assign done       = (state_reg == ST_DONE);
  assign busy       = (state_reg == ST_ARMED) || (state_reg == ST_WAIT_TRIG) ||
                      (state_reg == ST_CAPTURE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized and directed bench for adc_capture_ctrl; expectations come from an
// event-time model (trigger edge, write edges, end edge) computed per capture run.
module tb_adc_capture_ctrl;

  localparam int MAXN  = 256;
  localparam int ARM_C = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  adc_code_in = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        sw_trig = 1'b0;
  logic [1:0]  trig_mode = '0;
  logic [9:0]  trig_level = '0;
  logic [15:0] num_samples = '0;
  logic [7:0]  decim = '0;
  logic [23:0] timeout = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [9:0]  fifo_din;
  logic        busy;
  logic        done;
  logic        ovf_err;
  logic        tmo_err;
  logic [15:0] sample_cnt;
  logic [2:0]  state;

  adc_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .adc_code_in(adc_code_in), .arm(arm), .abort(abort),
    .sw_trig(sw_trig), .trig_mode(trig_mode), .trig_level(trig_level),
    .num_samples(num_samples), .decim(decim), .timeout(timeout), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .done(done),
    .ovf_err(ovf_err), .tmo_err(tmo_err), .sample_cnt(sample_cnt), .state(state)
  );

  initial forever #5 clk = ~clk;

  // stimulus per cycle
  logic [9:0] code_a [MAXN];
  bit         swt_a  [MAXN];
  bit         full_a [MAXN];
  bit         arm_a  [MAXN];
  bit         abort_a[MAXN];
  // expected outputs per cycle
  int         exp_st_a [MAXN];
  int         exp_cnt_a[MAXN];
  bit         exp_wr_a [MAXN];
  bit         exp_ovf_a[MAXN];
  bit         exp_tmo_a[MAXN];
  logic [9:0] exp_din_a[MAXN];

  int cfg_mode, cfg_level, cfg_num, cfg_decim, cfg_tmo, abort_cyc;
  bit spare_en;
  int prev_st, prev_cnt;
  bit prev_ovf, prev_tmo;

  int         e_st, e_cnt;
  bit         e_wr, e_ovf, e_tmo;
  logic [9:0] e_din;

  int         checks = 0;
  int         errors = 0;
  int         cur_c = 0;
  bit         chk_en = 1'b0;
  logic [9:0] cap_q[$];
  int         wait_cycles;
  int         st_hist[MAXN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cur_c, act, expv);
    end
  endtask

  // Single per-cycle compare process against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(e_st));
      chk("wr_en", 32'(fifo_wr_en), 32'(e_wr));
      if (e_wr) chk("din", 32'(fifo_din), 32'(e_din));
      chk("sample_cnt", 32'(sample_cnt), 32'(e_cnt));
      chk("ovf_err", 32'(ovf_err), 32'(e_ovf));
      chk("tmo_err", 32'(tmo_err), 32'(e_tmo));
      chk("busy", 32'(busy), 32'((e_st >= 1) && (e_st <= 3)));
      chk("done", 32'(done), 32'(e_st == 4));
      if (fifo_wr_en) cap_q.push_back(fifo_din);
      if (state == 3'd2) wait_cycles++;
    end
  end

  function automatic bit trig_ok(input int w);
    int p, c;
    p = int'(code_a[w-1]);
    c = int'(code_a[w]);
    case (cfg_mode)
      0:       return 1'b1;
      1:       return swt_a[w];
      2:       return (p < cfg_level) && (c >= cfg_level);
      default: return (p >= cfg_level) && (c < cfg_level);
    endcase
  endfunction

  // Model: locate trigger edge, write edges and end edge, then derive each cycle's outputs.
  task automatic build_model(input int n, input bit allow_open);
    int a, t, endc, b, wc, lim, lastc, nw;
    bit ovf_ev, tmo_ev, is_wr;
    int wr_at[$];
    a = ARM_C; t = -1; endc = -1; ovf_ev = 0; tmo_ev = 0;
    if (cfg_num == 0) endc = a + 1;
    else begin
      for (int w = a + 2; w < n; w++) begin
        if (trig_ok(w)) begin t = w; break; end
        if (cfg_tmo != 0 && (w - a - 1) == cfg_tmo) begin endc = w; tmo_ev = 1; break; end
      end
      if (t >= 0) begin
        for (int j = 0; j < cfg_num; j++) begin
          wc = t + j * (cfg_decim + 1);
          if (wc >= n) break;
          if (full_a[wc]) begin endc = wc; ovf_ev = 1; break; end
          wr_at.push_back(wc);
          if (j == cfg_num - 1) endc = wc;
        end
      end
    end
    b = abort_cyc;
    if (b < 0 && endc < 0 && !allow_open) b = n - 5;
    if (b >= 0) abort_a[b] = 1;
    if (spare_en) begin
      lim = (b >= 0) ? b : endc;
      if (endc >= 0 && endc < lim) lim = endc;
      if (lim >= a + 1) arm_a[$urandom_range(a + 1, lim)] = 1;
    end
    for (int c = 0; c < n; c++) begin
      if (c < a) begin
        exp_st_a[c] = prev_st; exp_cnt_a[c] = prev_cnt;
        exp_ovf_a[c] = prev_ovf; exp_tmo_a[c] = prev_tmo; exp_wr_a[c] = 0;
      end else begin
        lastc = (b >= 0 && c >= b) ? b - 1 : c;
        nw = 0; is_wr = 0;
        foreach (wr_at[k]) begin
          if (wr_at[k] <= lastc) nw++;
          if (wr_at[k] == c && c == lastc) is_wr = 1;
        end
        exp_cnt_a[c] = nw;
        exp_wr_a[c]  = is_wr;
        exp_ovf_a[c] = ovf_ev && endc <= lastc;
        exp_tmo_a[c] = tmo_ev && endc <= lastc;
        if (b >= 0 && c >= b)             exp_st_a[c] = 0;
        else if (c == a)                  exp_st_a[c] = 1;
        else if (endc >= 0 && c >= endc)  exp_st_a[c] = 4;
        else if (t >= 0 && c >= t)        exp_st_a[c] = 3;
        else                              exp_st_a[c] = 2;
      end
      exp_din_a[c] = code_a[c];
    end
    prev_st  = exp_st_a[n-1];
    prev_cnt = exp_cnt_a[n-1];
    prev_ovf = exp_ovf_a[n-1];
    prev_tmo = exp_tmo_a[n-1];
  endtask

  task automatic clear_stim(input int n);
    for (int c = 0; c < n; c++) begin
      code_a[c] = '0; swt_a[c] = 0; full_a[c] = 0; arm_a[c] = 0; abort_a[c] = 0;
    end
    arm_a[ARM_C] = 1;
    abort_cyc = -1;
    spare_en = 0;
  endtask

  // Entered and left just after a falling edge; inputs for cycle c are sampled at edge c.
  task automatic run_case(input int n, input bit allow_open, input string name);
    build_model(n, allow_open);
    cap_q.delete();
    wait_cycles = 0;
    for (int c = 0; c < n; c++) begin
      arm = arm_a[c]; abort = abort_a[c]; sw_trig = swt_a[c];
      adc_code_in = code_a[c]; fifo_full = full_a[c];
      if (c == ARM_C) begin
        trig_mode = 2'(cfg_mode); trig_level = 10'(cfg_level); num_samples = 16'(cfg_num);
        decim = 8'(cfg_decim); timeout = 24'(cfg_tmo);
      end else begin
        trig_mode = 2'($urandom); trig_level = 10'($urandom); num_samples = 16'($urandom);
        decim = 8'($urandom); timeout = 24'($urandom);
      end
      @(posedge clk);
      #1;
      cur_c = c;
      e_st = exp_st_a[c]; e_cnt = exp_cnt_a[c]; e_wr = exp_wr_a[c];
      e_ovf = exp_ovf_a[c]; e_tmo = exp_tmo_a[c]; e_din = exp_din_a[c];
      st_hist[c] = int'(state);
      chk_en = 1'b1;
      @(negedge clk);
      #1;
    end
    arm = 0; abort = 0; sw_trig = 0;
    $display("run %s: mode=%0d num=%0d decim=%0d tmo=%0d writes=%0d end_state=%0d",
             name, cfg_mode, cfg_num, cfg_decim, cfg_tmo, cap_q.size(), state);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_state"}, 32'(state), 0);
    chk({name, "_wr_en"}, 32'(fifo_wr_en), 0);
    chk({name, "_din"}, 32'(fifo_din), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_ovf"}, 32'(ovf_err), 0);
    chk({name, "_tmo"}, 32'(tmo_err), 0);
    chk({name, "_cnt"}, 32'(sample_cnt), 0);
  endtask

  task automatic set_cfg(input int m, input int lvl, input int num, input int dc, input int tmo);
    cfg_mode = m; cfg_level = lvl; cfg_num = num; cfg_decim = dc; cfg_tmo = tmo;
  endtask

  initial begin
    prev_st = 0; prev_cnt = 0; prev_ovf = 0; prev_tmo = 0;
    #3;
    check_zero("reset");
    #9 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // T1 immediate, ramp input
    clear_stim(20);
    for (int c = 0; c < 20; c++) code_a[c] = 10'(c);
    set_cfg(0, 0, 4, 0, 0);
    run_case(20, 0, "T1");
    chk("T1_nwr", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("T1_first", 32'(cap_q[0]), 4);
      chk("T1_last", 32'(cap_q[3]), 7);
    end
    chk("T1_cnt", 32'(sample_cnt), 4);
    chk("T1_done", 32'(done), 1);

    // T2 rising level trigger with decimation
    clear_stim(30);
    for (int c = 0; c < 30; c++) code_a[c] = (c < 3) ? 10'd490 : 10'(500 + 10 * (c - 3));
    set_cfg(2, 512, 3, 2, 0);
    run_case(30, 0, "T2");
    chk("T2_nwr", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("T2_w0", 32'(cap_q[0]), 520);
      chk("T2_w1", 32'(cap_q[1]), 550);
      chk("T2_w2", 32'(cap_q[2]), 580);
    end

    // T3 software mode with no trigger: timeout
    clear_stim(115);
    for (int c = 0; c < 115; c++) code_a[c] = 10'($urandom);
    set_cfg(1, 0, 5, 0, 100);
    run_case(115, 0, "T3");
    chk("T3_wait", wait_cycles, 100);
    chk("T3_tmo", 32'(tmo_err), 1);
    chk("T3_cnt", 32'(sample_cnt), 0);
    chk("T3_nwr", cap_q.size(), 0);

    // T4 FIFO full at the fourth write
    clear_stim(20);
    for (int c = 0; c < 20; c++) begin code_a[c] = 10'(c); full_a[c] = (c >= 7); end
    set_cfg(0, 0, 10, 0, 0);
    run_case(20, 0, "T4");
    chk("T4_nwr", cap_q.size(), 3);
    chk("T4_ovf", 32'(ovf_err), 1);
    chk("T4_cnt", 32'(sample_cnt), 3);
    chk("T4_done", 32'(done), 1);

    // T5 abort after two writes, then a clean re-arm
    clear_stim(15);
    for (int c = 0; c < 15; c++) code_a[c] = 10'(c);
    abort_cyc = 6;
    set_cfg(0, 0, 10, 0, 0);
    run_case(15, 0, "T5");
    chk("T5_nwr", cap_q.size(), 2);
    chk("T5_cnt", 32'(sample_cnt), 2);
    chk("T5_state", 32'(state), 0);
    chk("T5_done", 32'(done), 0);
    clear_stim(15);
    for (int c = 0; c < 15; c++) code_a[c] = 10'(100 + c);
    set_cfg(0, 0, 3, 0, 0);
    run_case(15, 0, "T5b");
    chk("T5b_nwr", cap_q.size(), 3);
    if (cap_q.size() == 3) chk("T5b_first", 32'(cap_q[0]), 104);
    chk("T5b_cnt", 32'(sample_cnt), 3);
    chk("T5b_ovf", 32'(ovf_err), 0);

    // T6 asynchronous reset mid-capture, then an empty capture
    clear_stim(10);
    for (int c = 0; c < 10; c++) code_a[c] = 10'(c + 1);
    set_cfg(0, 0, 50, 1, 0);
    run_case(10, 1, "T6");
    chk_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero("T6_async");
    @(posedge clk);
    #3 rst_n = 1'b1;
    prev_st = 0; prev_cnt = 0; prev_ovf = 0; prev_tmo = 0;
    @(negedge clk);
    #1;
    clear_stim(10);
    set_cfg(0, 0, 0, 0, 0);
    run_case(10, 0, "T6b");
    chk("T6b_armed", st_hist[ARM_C], 1);
    chk("T6b_done", st_hist[ARM_C + 1], 4);
    chk("T6b_nwr", cap_q.size(), 0);

    // Randomized captures
    for (int r = 0; r < 60; r++) begin
      clear_stim(160);
      set_cfg($urandom_range(0, 3), $urandom_range(100, 900),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8),
              $urandom_range(0, 4),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0);
      begin
        bit full_on;
        full_on = ($urandom_range(0, 2) == 0);
        for (int c = 0; c < 160; c++) begin
          code_a[c] = 10'($urandom);
          swt_a[c]  = ($urandom_range(0, 15) == 0);
          full_a[c] = full_on && ($urandom_range(0, 11) == 0);
        end
      end
      abort_cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 155) : -1;
      spare_en = ($urandom_range(0, 1) == 1);
      run_case(160, 0, "rnd");
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
